dsp_vector_sub_pipeline: RTL and testbench

- 4-lane, 8-bit unsigned SIMD vector subtractor: y_i = a_i - b_i. It is the inverse-direction counterpart to the team's DSP vector-add pipeline.
- Lanes are packed into 12-bit slots of a 48-bit word, matching DSP48E2 USE_SIMD="FOUR12". Minuend goes on C/Z, subtrahend on A:B/X, ALUMODE=0011 (Z-(X+Y+CIN)).
- Adds a valid/ready handshake, a stallable pipeline of configurable depth, and per-lane borrow flags. Sits between vector producers and consumers that need a flow-controlled lane-wise difference.

---
 rtl/dsp_vector_sub_pipeline_if.sv | 24 ++
 rtl/dsp_vector_sub_pipeline.sv | 125 ++++++++++++
 tb/tb_dsp_vector_sub_pipeline.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_vector_sub_pipeline_if.sv
// Stream interface for dsp_vector_sub_pipeline: four minuend/subtrahend lanes in,
// four difference lanes plus per-lane borrow out, each side with valid/ready.
interface dsp_vector_sub_pipeline_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] a_0, a_1, a_2, a_3;
  logic [WIDTH-1:0] b_0, b_1, b_2, b_3;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y_0, y_1, y_2, y_3;
  logic [3:0]       borrow;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a_0, a_1, a_2, a_3, b_0, b_1, b_2, b_3, in_valid, out_ready,
    input  in_ready, y_0, y_1, y_2, y_3, borrow, out_valid
  );

  modport slave (
    input  a_0, a_1, a_2, a_3, b_0, b_1, b_2, b_3, in_valid, out_ready,
    output in_ready, y_0, y_1, y_2, y_3, borrow, out_valid
  );
endinterface

// File: rtl/dsp_vector_sub_pipeline.sv
// 4-lane unsigned SIMD subtractor in DSP48E2 FOUR12 packing with a globally stalled
// valid/ready pipeline. Define DSP_VECTOR_SUB_SATURATE_EN to clamp borrowed lanes to 0.
module dsp_vector_sub_pipeline #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 2
) (
  input logic                   clock,
  input logic                   reset,
  dsp_vector_sub_pipeline_if.slave s
);

  logic             advance;
  logic [47:0]      c_in, ab_in;
  logic [47:0]      sub_z, sub_x;
  logic             sub_v;
  logic [WIDTH-1:0] res_y [4];
  logic [3:0]       res_b;
  logic [3:0]       unused_mid;
  logic             p_v;
  logic [WIDTH-1:0] p_y [4];
  logic [3:0]       p_b;

  assign advance    = s.out_ready | ~p_v;
  assign s.in_ready = advance;

  // Each lane sits zero-extended in its own 12-bit slot; bit 11 becomes the borrow.
  always_comb begin
    c_in  = '0;
    ab_in = '0;
    c_in[11:0]   = 12'(s.a_0);
    c_in[23:12]  = 12'(s.a_1);
    c_in[35:24]  = 12'(s.a_2);
    c_in[47:36]  = 12'(s.a_3);
    ab_in[11:0]  = 12'(s.b_0);
    ab_in[23:12] = 12'(s.b_1);
    ab_in[35:24] = 12'(s.b_2);
    ab_in[47:36] = 12'(s.b_3);
  end

  // Operand stages 1..LATENCY-1 carry packed operands; the subtract feeds the last stage.
  for (genvar k = 0; k < int'(LATENCY) - 1; k++) begin : g_op
    logic [47:0] z, x, z_d, x_d;
    logic        v, v_d;

    if (k == 0) begin : g_src
      always_comb begin
        z_d = c_in;
        x_d = ab_in;
        v_d = s.in_valid;
      end
    end else begin : g_src
      always_comb begin
        z_d = g_op[k-1].z;
        x_d = g_op[k-1].x;
        v_d = g_op[k-1].v;
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        v <= 1'b0;
        z <= '0;
        x <= '0;
      end else if (advance) begin
        v <= v_d;
        if (v_d) begin
          z <= z_d;
          x <= x_d;
        end
      end
    end
  end

  if (LATENCY == 1) begin : g_sub_src
    always_comb begin
      sub_z = c_in;
      sub_x = ab_in;
      sub_v = s.in_valid;
    end
  end else begin : g_sub_src
    always_comb begin
      sub_z = g_op[LATENCY-2].z;
      sub_x = g_op[LATENCY-2].x;
      sub_v = g_op[LATENCY-2].v;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [11:0] diff;
    always_comb begin
      diff     = sub_z[12*i +: 12] - sub_x[12*i +: 12];
      res_b[i] = diff[11];
`ifdef DSP_VECTOR_SUB_SATURATE_EN
      res_y[i] = diff[11] ? '0 : diff[WIDTH-1:0];
`else
      res_y[i] = diff[WIDTH-1:0];
`endif
      unused_mid[i] = ^diff;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_v <= 1'b0;
      p_y <= '{default: '0};
      p_b <= '0;
    end else if (advance) begin
      p_v <= sub_v;
      if (sub_v) begin
        p_y <= res_y;
        p_b <= res_b;
      end
    end
  end

  always_comb begin
    s.out_valid = p_v;
    s.y_0       = p_y[0];
    s.y_1       = p_y[1];
    s.y_2       = p_y[2];
    s.y_3       = p_y[3];
    s.borrow    = p_b;
  end

endmodule

// File: tb/tb_dsp_vector_sub_pipeline.sv
// Self-checking bench for dsp_vector_sub_pipeline: directed vectors plus a lane-wise
// integer reference model with an in-order expectation queue.
module tb_dsp_vector_sub_pipeline;
  parameter int LAT = 2;
  localparam int W = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dsp_vector_sub_pipeline_if #(.WIDTH(W)) vif ();

  dsp_vector_sub_pipeline #(.WIDTH(W), .LATENCY(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .s     (vif)
  );

  typedef struct {
    logic [4*W-1:0] y;
    logic [3:0]     br;
    int             cyc;
    int             st;
  } exp_t;

  exp_t exp_q[$];
  int   xfer_cyc[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   stalls = 0;
  bit   prev_hold = 1'b0;
  logic [4*W-1:0] prev_y;
  logic [3:0]     prev_br;
  bit   prod_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*W-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {W'(l3), W'(l2), W'(l1), W'(l0)};
  endfunction

  function automatic logic [4*W-1:0] get_y();
    return {vif.y_3, vif.y_2, vif.y_1, vif.y_0};
  endfunction

  // Reference: plain integer difference per lane, wrapped (or clamped) into WIDTH bits.
  task automatic model(input logic [4*W-1:0] av, input logic [4*W-1:0] bv,
                       output logic [4*W-1:0] y, output logic [3:0] br);
    y  = '0;
    br = '0;
    for (int i = 0; i < 4; i++) begin
      int d, r;
      d = int'(av[i*W +: W]) - int'(bv[i*W +: W]);
      br[i] = (d < 0);
      r = (d < 0) ? d + (1 << W) : d;
`ifdef DSP_VECTOR_SUB_SATURATE_EN
      if (d < 0) r = 0;
`endif
      y[i*W +: W] = r[W-1:0];
    end
  endtask

  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (vif.out_valid && !vif.out_ready) stalls++;
      if (prev_hold) begin
        chk("hold_valid", vif.out_valid, 1);
        chk("hold_y", get_y(), prev_y);
        chk("hold_borrow", vif.borrow, prev_br);
      end
      if (vif.out_valid && exp_q.size() == 0) begin
        chk("phantom_out_valid", vif.out_valid, 0);
      end else if (vif.out_valid && vif.out_ready) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_y", get_y(), e.y);
        chk("out_borrow", vif.borrow, e.br);
        if (e.st == stalls) chk("latency", cyc - e.cyc, LAT);
        xfer_cyc.push_back(cyc);
      end
      if (vif.in_valid && vif.in_ready) begin
        exp_t e;
        logic [4*W-1:0] ty;
        logic [3:0]     tb;
        model({vif.a_3, vif.a_2, vif.a_1, vif.a_0}, {vif.b_3, vif.b_2, vif.b_1, vif.b_0}, ty, tb);
        e.y = ty; e.br = tb; e.cyc = cyc; e.st = stalls;
        exp_q.push_back(e);
      end
      prev_hold = vif.out_valid && !vif.out_ready;
      prev_y    = get_y();
      prev_br   = vif.borrow;
    end
  end

  task automatic send_beat(input logic [4*W-1:0] av, input logic [4*W-1:0] bv);
    int n;
    {vif.a_3, vif.a_2, vif.a_1, vif.a_0} = av;
    {vif.b_3, vif.b_2, vif.b_1, vif.b_0} = bv;
    vif.in_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!vif.in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 0, 1);
    @(posedge clock);
    #1;
    vif.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || vif.out_valid) && n < 500) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 500) chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_out_valid(output int n);
    n = 1;
    while (!vif.out_valid && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 50) chk("out_valid_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int sz;
    vif.a_0 = '0; vif.a_1 = '0; vif.a_2 = '0; vif.a_3 = '0;
    vif.b_0 = '0; vif.b_1 = '0; vif.b_2 = '0; vif.b_3 = '0;
    vif.in_valid  = 1'b0;
    vif.out_ready = 1'b0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", vif.out_valid, 0);
    chk("rst_in_ready", vif.in_ready, 1);
    chk("rst_y", get_y(), 0);
    chk("rst_borrow", vif.borrow, 0);
    reset = 1'b1;
    vif.out_ready = 1'b1;

    // Single beat with hand-computed results.
    send_beat(pack4(10, 20, 30, 40), pack4(3, 20, 31, 0));
    wait_out_valid(n);
    chk("beat1_latency", n, LAT);
    chk("beat1_y0", vif.y_0, 7);
    chk("beat1_y1", vif.y_1, 0);
`ifdef DSP_VECTOR_SUB_SATURATE_EN
    chk("beat1_y2", vif.y_2, 0);
`else
    chk("beat1_y2", vif.y_2, 255);
`endif
    chk("beat1_y3", vif.y_3, 40);
    chk("beat1_borrow", vif.borrow, 4'b0100);
    drain();

    // Eight back-to-back beats.
    for (int k = 0; k < 8; k++) begin
      chk("stream_in_ready", vif.in_ready, 1);
      send_beat(pack4(k * 16, k * 3, 200 - k, 5), pack4(k, k * 5, 100, 5 + k));
    end
    drain();
    sz = xfer_cyc.size();
    for (int k = 1; k < 8; k++) chk("stream_no_bubble", xfer_cyc[sz-8+k] - xfer_cyc[sz-9+k], 1);

    // Stall with beats queued behind the output.
    vif.out_ready = 1'b0;
    fork
      begin
        send_beat(pack4(50, 60, 70, 80), pack4(1, 2, 3, 4));
        send_beat(pack4(5, 6, 7, 8), pack4(9, 6, 3, 200));
        send_beat(pack4(255, 1, 2, 3), pack4(254, 2, 2, 0));
      end
      begin
        int m;
        wait_out_valid(m);
        repeat (5) begin
          @(posedge clock);
          #1;
          chk("stall_in_ready", vif.in_ready, 0);
          chk("stall_out_valid", vif.out_valid, 1);
        end
        vif.out_ready = 1'b1;
      end
    join
    drain();

    // Boundary lanes.
    send_beat(pack4(0, 255, 128, 0), pack4(255, 0, 128, 1));
    wait_out_valid(n);
`ifdef DSP_VECTOR_SUB_SATURATE_EN
    chk("bound_y", get_y(), pack4(0, 255, 0, 0));
`else
    chk("bound_y", get_y(), pack4(1, 255, 0, 255));
`endif
    chk("bound_borrow", vif.borrow, 4'b1001);
    drain();

    // Asynchronous reset with beats in flight.
    send_beat(pack4(9, 9, 9, 9), pack4(1, 1, 1, 1));
    send_beat(pack4(8, 8, 8, 8), pack4(2, 2, 2, 2));
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_valid", vif.out_valid, 0);
    chk("midrst_in_ready", vif.in_ready, 1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (5) begin
      @(posedge clock);
      #1;
      chk("post_reset_quiet", vif.out_valid, 0);
    end

    // 100 random beats with random consumer back-pressure.
    prod_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 100; k++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clock);
            #1;
          end
          send_beat(32'($urandom), 32'($urandom));
        end
        prod_done = 1'b1;
      end
      begin
        while (!prod_done) begin
          @(posedge clock);
          #1;
          vif.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    vif.out_ready = 1'b1;
    drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
